alu_shift_sequencer: RTL and testbench
======================================

Name: alu_shift_sequencer

Overview:
- Multi-cycle sequencer that sits directly upstream of the single-cycle ALU.
- Performs an N-bit logical shift by issuing N successive one-bit LSH/RSH ops to the ALU.
- Registers each ALU result back into its working register and signals completion with a Done pulse.
- Gives the processor variable-amount shifts without adding a barrel shifter to the ALU.

Parameters:
W, 8, datapath width; must match ALU InputA/Out width
CNT_W, 4, width of Amount and of the internal step counter

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Dir  input  1  0 = left shift (LSH), 1 = right shift (RSH)
Amount  input  CNT_W  shift count; values >W saturate to W
DataIn  input  W  operand to shift
FillBit  input  1  bit inserted at LSB on each LSH step
AluA  output  W  ALU InputA = working register
AluB  output  W  ALU InputB; constant 0
AluOp  output  4  LSH (4'b0000) or RSH (4'b0001) from shared package
AluSC  output  1  ALU SC_in = latched FillBit
AluOut  input  W  ALU Out, combinational from AluA/AluOp
AluZero  input  1  ALU Zero; unused except for lint tie-off
Busy  output  1  high in SHIFT and DONE
Done  output  1  one-cycle completion pulse
Result  output  W  final shifted value; held until next accepted Start
ZeroFlag  output  1  Result == 0; registered with Result
ShiftOut  output  1  last bit shifted out; 0 if Amount == 0

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset: state=IDLE; working reg, counter, Result, ZeroFlag, ShiftOut, Done, Busy = 0.
- Reset has priority over all other events, including mid-SHIFT. An in-flight operation is discarded with no Done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On Start=1, latch DataIn→work, Dir, FillBit, and cnt = min(Amount, W).
  - If the latched cnt==0, go to DONE; otherwise go to SHIFT.
  - Start=0: remain in IDLE.
- SHIFT: each cycle, work ← AluOut.
  - ShiftOut ← work[W-1] when Dir=0, or work[0] when Dir=1, taken before the update.
  - cnt ← cnt−1. When cnt==1, the current step is the last one; go to DONE.
- DONE:
  - Result ← work, ZeroFlag ← (work==0), Done=1 for exactly this cycle.
  - Go to IDLE. Start seen during DONE is ignored.
- Latency: Start accepted at edge k → Done high during the cycle after edge k+N, where N is the saturated count (N=0: cycle after edge k). Next Start accepted at edge k+N+2.
- Start while Busy=1 is ignored and has no side effects.
- Drive AluA/AluOp/AluSC from latched state in every state. AluB is always 0.
- RSH fill is 0, per the ALU definition. FillBit affects LSH only.
- Amount is unsigned. Saturation at W yields all-FillBit for LSH and all-zero for RSH.
- Result/ZeroFlag/ShiftOut are stable outside DONE. ShiftOut updates during SHIFT.

Optional Feature:
- Macro: SHIFT_SEQ_ARITH_EN.
- Defined:
  - Adds input port Arith (1 bit), latched at Start.
  - When Dir=1 and Arith=1, each step writes {sign, AluOut[W-2:0]} into work, where sign is the latched DataIn[W-1]. The result is an arithmetic right shift.
- Undefined: port absent; RSH is always logical.

Decomposition:
- Shared definitions package:
  - ALU opcode constants (LSH, RSH, etc., already present).
  - New enum shift_seq_state_t {IDLE, SHIFT, DONE}.
- No sub-module. The ALU is instantiated beside this block at the top level and in the bench.

Test Plan:
- LSH: DataIn=0x81, Amount=1, FillBit=0 → Result=0x02, ShiftOut=1, ZeroFlag=0; Done in cycle 2 after Start.
- RSH: DataIn=0x80, Amount=7 → Result=0x01, ShiftOut=0. Busy high for 8 cycles; Done pulse exactly 1 cycle.
- Amount=0, DataIn=0x5A → Result=0x5A, ShiftOut=0; Done in the cycle after Start.
- LSH: DataIn=0x00, Amount=12, FillBit=1 → saturates to 8 steps, Result=0xFF. RSH: DataIn=0x01, Amount=1 → Result=0x00, ZeroFlag=1.
- Start with DataIn=0x33 pulsed mid-SHIFT of a prior op → ignored; first op's Result unaffected. Reset asserted mid-SHIFT → next cycle state IDLE, all outputs 0, no Done.
- With SHIFT_SEQ_ARITH_EN: DataIn=0x80, Dir=1, Arith=1, Amount=3 → Result=0xF0.

Source files
------------

// File: rtl/alu_shift_sequencer_pkg.sv
// rtl/alu_shift_sequencer_pkg.sv - shared ALU opcodes and shift sequencer state encoding
package alu_shift_sequencer_pkg;

    localparam logic [3:0] ALU_LSH = 4'b0000;
    localparam logic [3:0] ALU_RSH = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_seq_state_t;

endpackage

// File: rtl/alu_shift_sequencer.sv
// rtl/alu_shift_sequencer.sv - N-step shifter driving the single-cycle ALU one bit per cycle
// Optional arithmetic right shift: define SHIFT_SEQ_ARITH_EN to add the Arith input.
module alu_shift_sequencer
    import alu_shift_sequencer_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Dir,
    input  logic [CNT_W-1:0] Amount,
    input  logic [W-1:0]     DataIn,
    input  logic             FillBit,
`ifdef SHIFT_SEQ_ARITH_EN
    input  logic             Arith,
`endif
    output logic [W-1:0]     AluA,
    output logic [W-1:0]     AluB,
    output logic [3:0]       AluOp,
    output logic             AluSC,
    input  logic [W-1:0]     AluOut,
    input  logic             AluZero,
    output logic             Busy,
    output logic             Done,
    output logic [W-1:0]     Result,
    output logic             ZeroFlag,
    output logic             ShiftOut
);

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(W);

    shift_seq_state_t state;
    logic [W-1:0]     work;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic             fill_q;
    logic [W-1:0]     result_q;
    logic             zero_q;
    logic             shout_q;
    logic             done_q;
    logic             busy_q;
    logic [W-1:0]     step_val;
    logic [CNT_W-1:0] sat_amount;
    logic             unused_alu_zero;

`ifdef SHIFT_SEQ_ARITH_EN
    logic             arith_q;
    logic             sign_q;
`endif

    assign unused_alu_zero = AluZero;
    assign sat_amount      = (Amount > W_CNT) ? W_CNT : Amount;

    // Arithmetic mode re-inserts the original sign over the ALU's zero fill.
    always_comb begin
        step_val = AluOut;
`ifdef SHIFT_SEQ_ARITH_EN
        if (dir_q && arith_q)
            step_val = {sign_q, AluOut[W-2:0]};
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            work     <= '0;
            cnt      <= '0;
            dir_q    <= 1'b0;
            fill_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            shout_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SHIFT_SEQ_ARITH_EN
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        work   <= DataIn;
                        dir_q  <= Dir;
                        fill_q <= FillBit;
                        cnt    <= sat_amount;
                        busy_q <= 1'b1;
`ifdef SHIFT_SEQ_ARITH_EN
                        arith_q <= Arith;
                        sign_q  <= DataIn[W-1];
`endif
                        if (sat_amount == '0) begin
                            state    <= DONE;
                            result_q <= DataIn;
                            zero_q   <= (DataIn == '0);
                            shout_q  <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work    <= step_val;
                    shout_q <= dir_q ? work[0] : work[W-1];
                    cnt     <= cnt - 1'b1;
                    // Result is captured on entry so it is valid alongside Done.
                    if (cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        result_q <= step_val;
                        zero_q   <= (step_val == '0);
                        done_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign AluA     = work;
    assign AluB     = '0;
    assign AluOp    = dir_q ? ALU_RSH : ALU_LSH;
    assign AluSC    = fill_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign ZeroFlag = zero_q;
    assign ShiftOut = shout_q;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// tb/tb_alu_shift_sequencer.sv - randomized self-checking bench with behavioural shift model
module tb_alu_shift_sequencer;
    import alu_shift_sequencer_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] amount;
    logic [W-1:0]     data_in;
    logic             fill_bit;
    logic             arith;
    logic [W-1:0]     alu_a, alu_b, alu_out;
    logic [3:0]       alu_op;
    logic             alu_sc, alu_zero;
    logic             busy, done, zero_flag, shift_out;
    logic [W-1:0]     result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_shift_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Dir(dir), .Amount(amount),
        .DataIn(data_in), .FillBit(fill_bit),
`ifdef SHIFT_SEQ_ARITH_EN
        .Arith(arith),
`endif
        .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .AluSC(alu_sc),
        .AluOut(alu_out), .AluZero(alu_zero), .Busy(busy), .Done(done),
        .Result(result), .ZeroFlag(zero_flag), .ShiftOut(shift_out)
    );

    // Single-cycle ALU that sits beside the sequencer
    always_comb begin
        case (alu_op)
            ALU_LSH: alu_out = {alu_a[W-2:0], alu_sc};
            ALU_RSH: alu_out = {1'b0, alu_a[W-1:1]};
            default: alu_out = alu_a + alu_b;
        endcase
    end
    assign alu_zero = (alu_out == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-operation model: the shift is computed in one step from arithmetic rules.
    task automatic model(input int d, input bit dr, input int amt, input bit fill, input bit ar,
                         output int res, output int so, output int n);
        n = (amt > W) ? W : amt;
        if (!dr) begin
            res = ((d << n) | (fill ? ((1 << n) - 1) : 0)) & 'hFF;
            so  = (n == 0) ? 0 : ((d >> (W - n)) & 1);
        end else begin
            if (ar && d[W-1])
                res = ((d | 'hFFFF_FF00) >>> n) & 'hFF;
            else
                res = (d >> n) & 'hFF;
            so  = (n == 0) ? 0 : ((d >> (n - 1)) & 1);
        end
    endtask

    task automatic run_op(input int d, input bit dr, input int amt, input bit fill, input bit ar,
                          input bit poke);
        int exp_res, exp_so, n, busy_cnt, done_at;
        model(d, dr, amt, fill, ar, exp_res, exp_so, n);
        @(negedge clk);
        start = 1'b1; dir = dr; amount = CNT_W'(amt); data_in = W'(d);
        fill_bit = fill; arith = ar;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_at = i;
                break;
            end
            if (poke && i == 1) begin
                start = 1'b1; data_in = 8'h33; dir = ~dr; amount = 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_latency", done_at, n);
        check("busy_cycles", busy_cnt, n + 1);
        check("result", result, exp_res);
        check("zero_flag", zero_flag, (exp_res == 0));
        check("shift_out", shift_out, exp_so);
        @(negedge clk);
        check("done_pulse_width", done, 0);
        check("busy_after_done", busy, 0);
        check("result_held", result, exp_res);
    endtask

    initial begin
        int res_dummy, so_dummy, n_dummy;
        bit ar;
        reset = 1'b1; start = 1'b0; dir = 1'b0; amount = '0; data_in = '0;
        fill_bit = 1'b0; arith = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        reset = 1'b0;

        run_op('h81, 0, 1, 0, 0, 0);
        run_op('h80, 1, 7, 0, 0, 0);
        run_op('h5A, 0, 0, 1, 0, 0);
        run_op('h00, 0, 12, 1, 0, 0);
        run_op('h01, 1, 1, 0, 0, 0);
        run_op('hA5, 1, 15, 1, 0, 0);
        run_op('hC3, 0, 4, 0, 0, 1);
`ifdef SHIFT_SEQ_ARITH_EN
        run_op('h80, 1, 3, 0, 1, 0);
        model('h80, 1, 3, 0, 1, res_dummy, so_dummy, n_dummy);
        check("arith_plan", result, 'hF0);
`endif

        // Reset in the middle of a long shift discards it
        @(negedge clk);
        start = 1'b1; dir = 1'b0; amount = 4'd8; data_in = 8'hFF; fill_bit = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_done", done, 0);
        check("mid_reset_result", result, 0);
        check("mid_reset_shift_out", shift_out, 0);
        check("mid_reset_alu_a", alu_a, 0);
        check("mid_reset_alu_sc", alu_sc, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (done || busy) seen++;
            end
            check("mid_reset_no_done", seen, 0);
        end

        for (int t = 0; t < 40; t++) begin
`ifdef SHIFT_SEQ_ARITH_EN
            ar = 1'($urandom_range(0, 1));
`else
            ar = 1'b0;
`endif
            run_op(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ar,
                   1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
